stage_pipe_buf: RTL and testbench

- Parametrised elastic pipeline-stage register. It is the successor to the fixed-width clear/stall stage flops between the decode, execute and memory stages.
- Replaces the global stall with a per-stage valid/ready handshake.
- Holds up to DEPTH in-flight payloads, so a downstream stall does not have to propagate combinationally upstream in the same cycle.
- Supports an immediate flush and a deferred (stall-respecting) flush, matching the trap vs. branch redirect semantics.

---
 rtl/stage_pipe_buf_pkg.sv | 18 +
 rtl/stage_pipe_buf_if.sv | 30 +++
 rtl/stage_pipe_buf_ctrl.sv | 77 +++++++
 rtl/stage_pipe_buf.sv | 55 +++++
 tb/tb_stage_pipe_buf.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/stage_pipe_buf_pkg.sv
// Shared stage-bundle widths and bubble (NOP) encodings for the elastic
// pipeline-stage buffers between decode, execute and memory.
package pipe_pkg;

  localparam int STAGE_IF_ID_W = 96;
  localparam int STAGE_ID_EX_W = 411;
  localparam int STAGE_EX_MA_W = 180;

  localparam logic [STAGE_IF_ID_W-1:0] BUBBLE_IF_ID = '0;
  localparam logic [STAGE_ID_EX_W-1:0] BUBBLE_ID_EX = '0;
  localparam logic [STAGE_EX_MA_W-1:0] BUBBLE_EX_MA = '0;

  // Ring pointer width; a single-entry ring still carries a 1-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stage_pipe_buf_if.sv
// Upstream/downstream handshake bundle of one elastic stage buffer.
interface stage_pipe_buf_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = STAGE_ID_EX_W,
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic             flush_defer;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, in_data, out_ready, flush, flush_defer,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush, flush_defer,
    output in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/stage_pipe_buf_ctrl.sv
// Ring control for the stage buffer: pointers, occupancy, readiness and
// the effective (immediate or stall-respecting) flush.
module pipe_buf_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int READY_PASS = 1,
  parameter int PTR_W      = ptr_w(DEPTH),
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             out_ready,
  input  logic             flush,
  input  logic             flush_defer,
  output logic             in_ready,
  output logic             out_valid,
  output logic             push,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic             pop;
  logic             flush_eff;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;

  // Explicit wrap so non-power-of-two depths never visit unused slots.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A branch flush waits until the head is not being held by a stall.
  assign flush_eff = flush | (flush_defer & (out_ready | ~out_valid));
  assign in_ready  = (count < DEPTH_C) | ((READY_PASS != 0) & pop);
  assign push      = in_valid & in_ready & ~flush_eff;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush_eff) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = ptr_inc(wr_ptr);
      if (pop)  rd_ptr_nxt = ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
    end
  end

endmodule

// File: rtl/stage_pipe_buf.sv
// Elastic pipeline-stage register: DEPTH-entry ring with valid/ready on both
// sides, registered-only in->out path and NOP bubble on an empty output.
module stage_pipe_buf
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = STAGE_ID_EX_W,
  parameter int               DEPTH      = 2,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
  parameter int               READY_PASS = 1
) (
  input logic              clk,
  input logic              rst_n,
  stage_pipe_buf_if.slave  bus
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             push;
  logic             out_valid;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] mem [DEPTH];

  pipe_buf_ctrl #(
    .DEPTH      (DEPTH),
    .READY_PASS (READY_PASS),
    .PTR_W      (PTR_W),
    .CNT_W      (CNT_W)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (bus.in_valid),
    .out_ready   (bus.out_ready),
    .flush       (bus.flush),
    .flush_defer (bus.flush_defer),
    .in_ready    (bus.in_ready),
    .out_valid   (out_valid),
    .push        (push),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count)
  );

  // Payload storage carries no reset; validity lives entirely in count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mem[rd_ptr] : BUBBLE_VAL;
  assign bus.count     = count;

endmodule

// File: tb/tb_stage_pipe_buf.sv
// Bench for stage_pipe_buf: directed handshake/flush scenarios on a DEPTH=2
// instance, randomized traffic with queue model on a DEPTH=3 instance.
module tb_stage_pipe_buf;
  import pipe_pkg::*;

  localparam int WA = STAGE_ID_EX_W;
  localparam int WB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  stage_pipe_buf_if #(.WIDTH(WA), .DEPTH(2)) ia ();
  stage_pipe_buf_if #(.WIDTH(WB), .DEPTH(3)) ib ();

  stage_pipe_buf #(.WIDTH(WA), .DEPTH(2), .BUBBLE_VAL('0), .READY_PASS(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  stage_pipe_buf #(.WIDTH(WB), .DEPTH(3), .BUBBLE_VAL('0), .READY_PASS(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  task automatic chk(input string tag, input logic [WA-1:0] obs, input logic [WA-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input bit v, input bit r, input int c, input logic [31:0] d);
    chk({tag, ".out_valid"}, WA'(ia.out_valid), WA'(v));
    chk({tag, ".in_ready"},  WA'(ia.in_ready),  WA'(r));
    chk({tag, ".count"},     WA'(ia.count),     WA'(c));
    chk({tag, ".out_data"},  ia.out_data,       WA'(d));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake legality on the randomized instance, from its ports alone.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic bit fe  = ib.flush | (ib.flush_defer & (ib.out_ready | ~ib.out_valid));
      automatic bit pu  = ib.in_valid & ib.in_ready & ~fe;
      automatic bit po  = ib.out_valid & ib.out_ready;
      total++;
      assert (!(pu && ib.count == 3 && !po)) else begin
        bad++;
        $error("FAIL push_when_full observed=push count=%0d expected=no_push", ib.count);
      end
      total++;
      assert (ib.count <= 3) else begin
        bad++;
        $error("FAIL count_bound observed=%0d expected<=3", ib.count);
      end
    end
  end

  initial begin
    logic [WB-1:0] q[$];
    bit            hold_v;
    int            sz;
    bit            pop, exp_ir, fe, push;

    ia.in_valid = 0; ia.in_data = '0; ia.out_ready = 0; ia.flush = 0; ia.flush_defer = 0;
    ib.in_valid = 0; ib.in_data = '0; ib.out_ready = 0; ib.flush = 0; ib.flush_defer = 0;

    #12;
    chk_a("rst", 0, 1, 0, 0);
    rst_n = 1'b1;
    step(); #2 chk_a("idle", 0, 1, 0, 0);

    // streaming, out_ready held high
    step(); ia.out_ready = 1; ia.in_valid = 1; ia.in_data = WA'(1); #2 chk_a("s0", 0, 1, 0, 0);
    step(); ia.in_data = WA'(2); #2 chk_a("s1", 1, 1, 1, 1);
    step(); ia.in_data = WA'(3); #2 chk_a("s2", 1, 1, 1, 2);
    step(); ia.in_valid = 0;     #2 chk_a("s3", 1, 1, 1, 3);
    step();                      #2 chk_a("s4", 0, 1, 0, 0);

    // backpressure
    step(); ia.out_ready = 0; ia.in_valid = 1; ia.in_data = WA'('hA); #2 chk_a("b0", 0, 1, 0, 0);
    step(); ia.in_data = WA'('hB); #2 chk_a("b1", 1, 1, 1, 'hA);
    step(); ia.in_data = WA'('hC); #2 chk_a("b2", 1, 0, 2, 'hA);
    step();                        #2 chk_a("b3", 1, 0, 2, 'hA);
    step(); ia.out_ready = 1;      #2 chk_a("b4", 1, 1, 2, 'hA);
    step(); ia.in_valid = 0;       #2 chk_a("b5", 1, 1, 2, 'hB);
    step();                        #2 chk_a("b6", 1, 1, 1, 'hC);
    step(); ia.out_ready = 0;      #2 chk_a("b7", 0, 1, 0, 0);

    // deferred flush held off by a stall, then applied with a pop
    step(); ia.in_valid = 1; ia.in_data = WA'('h11); #2 chk_a("d0", 0, 1, 0, 0);
    step(); ia.in_data = WA'('h22);                  #2 chk_a("d1", 1, 1, 1, 'h11);
    step(); ia.in_valid = 0; ia.flush_defer = 1;     #2 chk_a("d2", 1, 0, 2, 'h11);
    step();                                          #2 chk_a("d3", 1, 0, 2, 'h11);
    step(); ia.out_ready = 1; ia.in_valid = 1; ia.in_data = WA'('h55);
    #2 chk_a("d4", 1, 1, 2, 'h11);
    step(); ia.flush_defer = 0; ia.in_valid = 0; ia.out_ready = 0; #2 chk_a("d5", 0, 1, 0, 0);
    step();                                                         #2 chk_a("d6", 0, 1, 0, 0);

    // immediate flush drops the stall and the same-cycle input
    step(); ia.in_valid = 1; ia.in_data = WA'('h33); #2 chk_a("f0", 0, 1, 0, 0);
    step(); ia.in_data = WA'('h44);                  #2 chk_a("f1", 1, 1, 1, 'h33);
    step(); ia.flush = 1; ia.in_data = WA'('h77);    #2 chk_a("f2", 1, 0, 2, 'h33);
    step(); ia.flush = 0; ia.in_valid = 0;           #2 chk_a("f3", 0, 1, 0, 0);
    step(); ia.out_ready = 1;                        #2 chk_a("f4", 0, 1, 0, 0);

    // randomized traffic on DEPTH=3 against a FIFO-queue model
    hold_v = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (i == 500) begin
        #1 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", WA'(ib.out_valid), WA'(0));
        chk("arst.count",     WA'(ib.count),     WA'(0));
        chk("arst.out_data",  WA'(ib.out_data),  WA'(0));
        chk("arst.in_ready",  WA'(ib.in_ready),  WA'(1));
        q.delete();
        hold_v = 0;
        #1 rst_n = 1'b1;
      end
      if (!hold_v) begin
        ib.in_valid = ($urandom_range(0, 9) < 7);
        ib.in_data  = WB'($urandom);
      end
      ib.out_ready   = ($urandom_range(0, 9) < 6);
      ib.flush       = ($urandom_range(0, 49) == 0);
      ib.flush_defer = ($urandom_range(0, 29) == 0);
      #2;
      sz     = q.size();
      pop    = (sz > 0) && ib.out_ready;
      exp_ir = (sz < 3) || pop;
      chk("r.out_valid", WA'(ib.out_valid), WA'(sz > 0));
      chk("r.out_data",  WA'(ib.out_data),  WA'((sz > 0) ? q[0] : WB'(0)));
      chk("r.count",     WA'(ib.count),     WA'(sz));
      chk("r.in_ready",  WA'(ib.in_ready),  WA'(exp_ir));
      fe   = ib.flush || (ib.flush_defer && (ib.out_ready || sz == 0));
      push = ib.in_valid && exp_ir && !fe;
      if (pop) void'(q.pop_front());
      if (fe) q.delete();
      else if (push) q.push_back(ib.in_data);
      hold_v = ib.in_valid && !exp_ir && !fe;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
